dshot_rx: RTL and testbench

Next-generation DShot frame receiver for the DShot converter. It handles DShot150/300/600/1200, with the rate selected at runtime. It measures each pulse's active width in clk cycles rather than using fixed sample points, and it supports bidirectional (inverted) DShot. Decoded throttle/command fields and per-frame status strobes feed the downstream ESC/PWM output stage.

---
 rtl/dshot_rx.sv | 205 ++++++++++++++++++++
 tb/tb_dshot_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dshot_rx.sv
// DShot frame receiver: measures each active pulse width in clk cycles and decodes
// 16-bit frames at a runtime-selected rate, with optional inverted (bidirectional) line.
`timescale 1ns/1ps
module dshot_rx #(
  parameter int CLK_HZ   = 48000000,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  input  logic [1:0]  rate_sel,
  input  logic        invert,
  output logic        frame_valid,
  output logic [10:0] throttle,
  output logic [5:0]  command,
  output logic        is_command,
  output logic        telemetry_req,
  output logic        crc_err,
  output logic        frame_err,
  output logic        busy
);
  localparam int P_SLOW = CLK_HZ / 150000;
  localparam int CW     = $clog2(GAP_BITS * P_SLOW + 1) + 1;

  function automatic int bit_period(input int r);
    case (r)
      0:       return CLK_HZ / 150000;
      1:       return CLK_HZ / 300000;
      2:       return CLK_HZ / 600000;
      default: return CLK_HZ / 1200000;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DECODE} state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_sync;
  logic          r_act, r_act_d;
  logic [1:0]    r_rate;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bitcnt;
  logic [15:0]   r_shift;
  logic          r_frame_valid, r_crc_err, r_frame_err;
  logic [10:0]   r_throttle;
  logic [5:0]    r_command;
  logic          r_is_command, r_telemetry;

  logic [CW-1:0] w_th_tab [4];
  logic [CW-1:0] w_minw_tab [4];
  logic [CW-1:0] w_maxw_tab [4];
  logic [CW-1:0] w_to_tab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rate
      assign w_th_tab[gi]   = CW'(bit_period(gi) / 2);
      assign w_minw_tab[gi] = CW'(bit_period(gi) / 8);
      assign w_maxw_tab[gi] = CW'((7 * bit_period(gi)) / 8);
      assign w_to_tab[gi]   = CW'(GAP_BITS * bit_period(gi));
    end
  endgenerate

  logic          w_act, w_rise, w_fall;
  logic [CW-1:0] w_th, w_minw, w_maxw, w_to;
  logic [10:0]   w_value;
  logic [3:0]    w_crc;
  logic          w_crc_ok;

  assign w_act    = r_sync[1] ^ invert;
  assign w_rise   = r_act & ~r_act_d;
  assign w_fall   = ~r_act & r_act_d;
  assign w_th     = w_th_tab[r_rate];
  assign w_minw   = w_minw_tab[r_rate];
  assign w_maxw   = w_maxw_tab[r_rate];
  assign w_to     = w_to_tab[r_rate];
  assign w_value  = r_shift[15:5];
  assign w_crc    = r_shift[7:4] ^ r_shift[11:8] ^ r_shift[15:12] ^ {4{invert}};
  assign w_crc_ok = (w_crc == r_shift[3:0]);

  // Synchronizer idles at the inactive line level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= {2{invert}};
      r_act   <= 1'b0;
      r_act_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], din};
      r_act   <= w_act;
      r_act_d <= r_act;
    end
  end

  logic w_start, w_cnt_one, w_cnt_clr, w_cnt_inc, w_shift_en;
  logic w_good, w_bad_crc, w_bad_frame;

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_cnt_one    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_shift_en   = 1'b0;
    w_good       = 1'b0;
    w_bad_crc    = 1'b0;
    w_bad_frame  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_start      = 1'b1;
        end
      end
      HIGH: begin
        if (w_fall) begin
          if (r_cnt < w_minw || r_cnt > w_maxw) begin
            w_bad_frame  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_shift_en   = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_next = (r_bitcnt == 5'd15) ? DECODE : LOW;
          end
        end else if (r_cnt > w_maxw) begin
          w_bad_frame  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_state_next = HIGH;
          w_cnt_one    = 1'b1;
        end else if (r_cnt >= w_to) begin
          w_bad_frame  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DECODE: begin
        w_state_next = IDLE;
        if (w_crc_ok) w_good = 1'b1;
        else          w_bad_crc = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // The rising-edge cycle itself is counted, so r_cnt equals the pulse width at the fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rate        <= 2'd0;
      r_cnt         <= '0;
      r_bitcnt      <= 5'd0;
      r_shift       <= 16'd0;
      r_frame_valid <= 1'b0;
      r_crc_err     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_throttle    <= 11'd0;
      r_command     <= 6'd0;
      r_is_command  <= 1'b0;
      r_telemetry   <= 1'b0;
    end else begin
      if (w_start) begin
        r_rate   <= rate_sel;
        r_bitcnt <= 5'd0;
        r_cnt    <= CW'(1);
      end else if (w_cnt_one) begin
        r_cnt <= CW'(1);
      end else if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_shift_en) begin
        r_shift  <= {r_shift[14:0], (r_cnt > w_th)};
        r_bitcnt <= r_bitcnt + 5'd1;
      end
      r_frame_valid <= w_good;
      r_crc_err     <= w_bad_crc;
      r_frame_err   <= w_bad_frame;
      if (w_good) begin
        r_is_command <= (w_value < 11'd48);
        r_throttle   <= (w_value >= 11'd48) ? (w_value - 11'd48) : 11'd0;
        r_command    <= (w_value < 11'd48) ? w_value[5:0] : 6'd0;
        r_telemetry  <= r_shift[4];
      end
    end
  end

  assign frame_valid   = r_frame_valid;
  assign crc_err       = r_crc_err;
  assign frame_err     = r_frame_err;
  assign throttle      = r_throttle;
  assign command       = r_command;
  assign is_command    = r_is_command;
  assign telemetry_req = r_telemetry;
  assign busy          = (r_state != IDLE);
endmodule

// File: tb/tb_dshot_rx.sv
// Self-checking bench for dshot_rx: table of directed frames, hand-written corner
// sequences, and random frames checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dshot_rx;
  logic        clk = 1'b0;
  logic        reset, din, invert;
  logic [1:0]  rate_sel;
  logic        frame_valid, is_command, telemetry_req, crc_err, frame_err, busy;
  logic [10:0] throttle;
  logic [5:0]  command;

  dshot_rx #(.CLK_HZ(48000000), .GAP_BITS(2)) dut (
    .clk(clk), .reset(reset), .din(din), .rate_sel(rate_sel), .invert(invert),
    .frame_valid(frame_valid), .throttle(throttle), .command(command),
    .is_command(is_command), .telemetry_req(telemetry_req), .crc_err(crc_err),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int n_strobes = 0;

  always @(negedge clk)
    n_strobes += int'(frame_valid) + int'(crc_err) + int'(frame_err);

  // Reference model state: fields of the last good frame.
  int m_thr = 0, m_cmd = 0, m_isc = 0, m_tel = 0;

  typedef struct {
    logic [15:0] pkt;
    int          rate;
    bit          inv;
    int          kind;   // 1 = frame_valid, 2 = crc_err, 3 = frame_err
    int          thr;
    int          cmd;
    int          isc;
    int          tel;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int tb_period(input int r);
    int rates[4] = '{150000, 300000, 600000, 1200000};
    return 48000000 / rates[r];
  endfunction

  function automatic logic [15:0] make_pkt(input int value, input int tel, input bit inv, input int flip);
    int p, c;
    p = value * 2 + tel;
    c = (p % 16) ^ ((p / 16) % 16) ^ (p / 256);
    if (inv) c = 15 - c;
    c = c ^ flip;
    return 16'(p * 16 + c);
  endfunction

  task automatic drive(input bit level, input int n);
    din = level ^ invert;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends bits [first .. first+cnt-1] (MSB first); the last bit's low time is left to the caller.
  task automatic send_bits(input logic [15:0] pkt, input int first, input int cnt, input int p);
    for (int i = first; i < first + cnt; i++) begin
      int hi;
      hi = pkt[15 - i] ? (3 * p) / 4 : (3 * p) / 8;
      drive(1'b1, hi);
      if (i < first + cnt - 1) drive(1'b0, p - hi);
      else din = invert;
    end
  endtask

  // Called right after the final falling edge was driven: k counts clk edges after the first edge seeing it.
  task automatic finish_frame(input int maxk, output int kind, output int lat);
    kind = 0;
    lat  = -1;
    @(posedge clk);
    for (int k = 1; k <= maxk; k++) begin
      @(posedge clk);
      #1;
      if (kind == 0) begin
        if (frame_valid)    begin kind = 1; lat = k; end
        else if (crc_err)   begin kind = 2; lat = k; end
        else if (frame_err) begin kind = 3; lat = k; end
      end
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_thr"}, throttle, m_thr);
    check({tag, "_cmd"}, command, m_cmd);
    check({tag, "_isc"}, is_command, m_isc);
    check({tag, "_tel"}, telemetry_req, m_tel);
  endtask

  task automatic switch_mode(input bit inv);
    invert = inv;
    din    = inv;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_thr = 0; m_cmd = 0; m_isc = 0; m_tel = 0;
    check_fields("mode_rst");
    check("mode_rst_busy", busy, 0);
  endtask

  task automatic run_frame(input logic [15:0] pkt, input int rate, input int exp_kind, input string tag);
    int kind, lat, base;
    rate_sel = 2'(rate);
    base = n_strobes;
    send_bits(pkt, 0, 16, tb_period(rate));
    finish_frame(12, kind, lat);
    check({tag, "_kind"}, kind, exp_kind);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_nstrobe"}, n_strobes - base, 1);
    check({tag, "_busy"}, busy, 0);
    check_fields(tag);
    $display("[TB] %s frame %h rate %0d inv %0d -> kind %0d lat %0d thr %0d cmd %0d tel %0d",
             tag, pkt, rate, invert, kind, lat, throttle, command, telemetry_req);
    drive(1'b0, 20);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int kind, lat, base;

    vecs[0] = '{16'h82C6, 2, 1'b0, 1, 998,  0,  0, 0};
    vecs[1] = '{16'h00BB, 2, 1'b0, 1, 0,    5,  1, 1};
    vecs[2] = '{16'h82C7, 2, 1'b0, 2, 0,    5,  1, 1};
    vecs[3] = '{16'h82C9, 2, 1'b1, 1, 998,  0,  0, 0};
    vecs[4] = '{16'h82C6, 2, 1'b1, 2, 998,  0,  0, 0};
    vecs[5] = '{16'h0606, 3, 1'b0, 1, 0,    0,  0, 0};
    vecs[6] = '{16'h05FA, 1, 1'b0, 1, 0,    47, 1, 1};
    vecs[7] = '{16'hFFFF, 3, 1'b0, 1, 1999, 0,  0, 1};

    reset = 1'b1; din = 1'b0; invert = 1'b0; rate_sel = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_crc", crc_err, 0);
    check("rst_ferr", frame_err, 0);
    check_fields("rst");
    drive(1'b0, 5);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].inv != invert) switch_mode(vecs[i].inv);
      m_thr = vecs[i].thr; m_cmd = vecs[i].cmd; m_isc = vecs[i].isc; m_tel = vecs[i].tel;
      run_frame(vecs[i].pkt, vecs[i].rate, vecs[i].kind, $sformatf("vec%0d", i));
    end

    // Gap timeout after 8 bits at 150k, then a full frame at the same rate.
    rate_sel = 2'd0;
    base = n_strobes;
    send_bits(16'h82C6, 0, 8, 320);
    check("gap_busy", busy, 1);
    finish_frame(700, kind, lat);
    check("gap_kind", kind, 3);
    check("gap_lat_window", int'(lat >= 640 && lat <= 648), 1);
    check("gap_nstrobe", n_strobes - base, 1);
    check("gap_busy_after", busy, 0);
    $display("[TB] gap timeout -> kind %0d lat %0d", kind, lat);
    drive(1'b0, 20);
    m_thr = 998; m_cmd = 0; m_isc = 0; m_tel = 0;
    run_frame(16'h82C6, 0, 1, "slow");

    // Glitch shorter than the minimum pulse.
    rate_sel = 2'd2;
    base = n_strobes;
    drive(1'b1, 5);
    din = invert;
    finish_frame(15, kind, lat);
    check("glitch_kind", kind, 3);
    check("glitch_nstrobe", n_strobes - base, 1);
    check("glitch_busy", busy, 0);
    $display("[TB] glitch 5 cycles -> kind %0d lat %0d", kind, lat);
    drive(1'b0, 20);

    // Reset in the middle of a frame.
    base = n_strobes;
    send_bits(16'h82C6, 0, 8, 80);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 300);
    m_thr = 0; m_cmd = 0; m_isc = 0; m_tel = 0;
    check("midrst_nstrobe", n_strobes - base, 0);
    check("midrst_busy", busy, 0);
    check_fields("midrst");
    $display("[TB] reset mid-frame -> strobes %0d busy %0d", n_strobes - base, busy);

    // rate_sel changes after 4 bits; the frame keeps the latched 600k timing.
    rate_sel = 2'd2;
    base = n_strobes;
    send_bits(16'h82C6, 0, 4, 80);
    drive(1'b0, 50);
    rate_sel = 2'd0;
    send_bits(16'h82C6, 4, 12, 80);
    finish_frame(12, kind, lat);
    m_thr = 998; m_cmd = 0; m_isc = 0; m_tel = 0;
    check("ratechg_kind", kind, 1);
    check("ratechg_lat", lat, 4);
    check("ratechg_nstrobe", n_strobes - base, 1);
    check_fields("ratechg");
    $display("[TB] rate change mid-frame -> kind %0d lat %0d thr %0d", kind, lat, throttle);
    drive(1'b0, 20);

    // Random frames against the reference model.
    for (int i = 0; i < 12; i++) begin
      int value, tel, rate, flip;
      bit inv, bad;
      logic [15:0] pkt;
      value = $urandom_range(0, 2047);
      tel   = $urandom_range(0, 1);
      rate  = $urandom_range(1, 3);
      inv   = ($urandom_range(0, 4) == 0);
      bad   = ($urandom_range(0, 3) == 0);
      flip  = bad ? (1 << $urandom_range(0, 3)) : 0;
      if (inv != invert) switch_mode(inv);
      pkt = make_pkt(value, tel, inv, flip);
      if (!bad) begin
        m_thr = (value >= 48) ? value - 48 : 0;
        m_cmd = (value < 48) ? value : 0;
        m_isc = (value < 48) ? 1 : 0;
        m_tel = tel;
      end
      run_frame(pkt, rate, bad ? 2 : 1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
